// File: rtl/fp_div_pkg.sv
// Shared constants, status bit positions and state type for the divider
// result stage. The optional FP_DIV_STATUS_EN build widens FIFO entries to
// carry a per-result status nibble alongside the quotient.
package fp_div_pkg;

   localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
   localparam logic [30:0] FP_INF_MAG = 31'h7F800000;
   localparam logic [7:0]  FP_EXP_MAX = 8'hFF;

   // Status nibble layout: {ov, uf, inv, dz}
   localparam int ST_OV  = 3;
   localparam int ST_UF  = 2;
   localparam int ST_INV = 1;
   localparam int ST_DZ  = 0;

`ifdef FP_DIV_STATUS_EN
   localparam int FIFO_W = 36;
`else
   localparam int FIFO_W = 32;
`endif

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_e;

   // Exponent field of a single-precision word.
   function automatic logic [7:0] fp_exp(input logic [31:0] x);
      return x[30:23];
   endfunction

endpackage

// File: rtl/fp_div_classify.sv
// Purely combinational special-case filter for the divider output.
// Decides, in priority order, whether the quotient comes from the operand
// encodings alone or from the divider, and which exception bit it raises.
// Denormal operands are treated as zero, so div_m is only forwarded for
// finite nonzero operand pairs without overflow/underflow.
module fp_div_classify
   import fp_div_pkg::*;
(
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic [31:0] div_m,
   input  logic        div_overflow,
   input  logic        div_underflow,
   output logic [31:0] data,
   output logic [3:0]  status
);

   logic a_zero, a_inf, a_nan;
   logic b_zero, b_inf, b_nan;
   logic sgn;

   // Operand category decode
   always_comb begin
      a_zero = (fp_exp(op_a) == 8'h00);
      b_zero = (fp_exp(op_b) == 8'h00);
      a_inf  = (fp_exp(op_a) == FP_EXP_MAX) && (op_a[22:0] == 23'd0);
      b_inf  = (fp_exp(op_b) == FP_EXP_MAX) && (op_b[22:0] == 23'd0);
      a_nan  = (fp_exp(op_a) == FP_EXP_MAX) && (op_a[22:0] != 23'd0);
      b_nan  = (fp_exp(op_b) == FP_EXP_MAX) && (op_b[22:0] != 23'd0);
      sgn    = op_a[31] ^ op_b[31];
   end

   // First-match priority chain selecting the canonical result
   always_comb begin
      data   = 32'd0;
      status = 4'd0;
      if (a_nan || b_nan) begin
         data = FP_QNAN;
      end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
         data           = FP_QNAN;
         status[ST_INV] = 1'b1;
      end else if (a_inf) begin
         data = {sgn, FP_INF_MAG};
      end else if (b_inf) begin
         data = {sgn, 31'd0};
      end else if (b_zero) begin
         data          = {sgn, FP_INF_MAG};
         status[ST_DZ] = 1'b1;
      end else if (a_zero) begin
         data = {sgn, 31'd0};
      end else if (div_overflow) begin
         data          = {sgn, FP_INF_MAG};
         status[ST_OV] = 1'b1;
      end else if (div_underflow) begin
         data          = {sgn, 31'd0};
         status[ST_UF] = 1'b1;
      end else begin
         data = div_m;
      end
   end

endmodule

// File: rtl/fp_div_result_stage.sv
// Capture stage behind the combinational single-precision divider.
// Waits SETTLE_CYCLES with operands held, then samples the sanitized result
// into a 2-entry in-order FIFO and accumulates sticky exception flags.
// Optional build macro FP_DIV_STATUS_EN adds out_status (per-entry status)
// and res_count (wrapping push counter).
//
// Handshakes: input side transfers on the cycle where in_valid & in_ready;
// in_ready is a one-cycle pulse raised only at the end of the settle window
// when the registered FIFO count is below 2 (a same-cycle pop does not free
// a slot). Output side transfers on out_valid & out_ready; out_valid means
// the head entry is valid and out_data holds steady until it is accepted.
module fp_div_result_stage
   import fp_div_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic [31:0] div_m,
   input  logic        div_overflow,
   input  logic        div_underflow,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   input  logic        flag_clr,
   output logic        flag_ov,
   output logic        flag_uf,
   output logic        flag_inv,
   output logic        flag_dz
`ifdef FP_DIV_STATUS_EN
   ,
   output logic [3:0]  out_status,
   output logic [15:0] res_count
`endif
);

   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [1:0]          count_q, count_d;
   logic [FIFO_W-1:0]   ent0_q, ent0_d;
   logic [FIFO_W-1:0]   ent1_q, ent1_d;
   logic [3:0]          flags_q, flags_d;
`ifdef FP_DIV_STATUS_EN
   logic [15:0]         res_count_q, res_count_d;
`endif

   logic [31:0]         cls_data;
   logic [3:0]          cls_status;
   logic [FIFO_W-1:0]   entry_in;
   logic                push;
   logic                pop;

   fp_div_classify u_classify (
      .op_a          (op_a),
      .op_b          (op_b),
      .div_m         (div_m),
      .div_overflow  (div_overflow),
      .div_underflow (div_underflow),
      .data          (cls_data),
      .status        (cls_status)
   );

`ifdef FP_DIV_STATUS_EN
   assign entry_in = {cls_status, cls_data};
`else
   assign entry_in = cls_data;
`endif

   // Settle-window FSM: count down while operands are held, then offer a slot
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      in_ready = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = WAIT;
               cnt_d   = CNT_LOAD;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               in_ready = (count_q < 2'd2);
            end
            if (!in_valid) begin
               state_d = IDLE;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (in_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign push      = in_valid & in_ready;
   assign out_valid = (count_q != 2'd0);
   assign pop       = out_valid & out_ready;

   // Two-slot FIFO with entry 0 as head; head keeps its last value when drained
   always_comb begin
      ent0_d  = ent0_q;
      ent1_d  = ent1_q;
      count_d = count_q;
      case ({push, pop})
         2'b10: begin
            if (count_q == 2'd0) begin
               ent0_d = entry_in;
            end else begin
               ent1_d = entry_in;
            end
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            if (count_q == 2'd2) begin
               ent0_d = ent1_q;
            end
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            // Only reachable at count 1: the new entry replaces the popped head
            ent0_d = entry_in;
         end
         default: begin
            count_d = count_q;
         end
      endcase
   end

   // Sticky flags: clear drops old bits, a capture in the same cycle still sets
   always_comb begin
      flags_d = (flag_clr ? 4'd0 : flags_q) | (push ? cls_status : 4'd0);
`ifdef FP_DIV_STATUS_EN
      res_count_d = res_count_q + (push ? 16'd1 : 16'd0);
`endif
   end

   // State, FIFO and flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         count_q     <= 2'd0;
         ent0_q      <= '0;
         ent1_q      <= '0;
         flags_q     <= 4'd0;
`ifdef FP_DIV_STATUS_EN
         res_count_q <= 16'd0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         count_q     <= count_d;
         ent0_q      <= ent0_d;
         ent1_q      <= ent1_d;
         flags_q     <= flags_d;
`ifdef FP_DIV_STATUS_EN
         res_count_q <= res_count_d;
`endif
      end
   end

   assign out_data = ent0_q[31:0];
   assign flag_ov  = flags_q[ST_OV];
   assign flag_uf  = flags_q[ST_UF];
   assign flag_inv = flags_q[ST_INV];
   assign flag_dz  = flags_q[ST_DZ];
`ifdef FP_DIV_STATUS_EN
   assign out_status = ent0_q[35:32];
   assign res_count  = res_count_q;
`endif

endmodule

// File: tb/tb_fp_div_result_stage.sv
// Bench for fp_div_result_stage: directed scenarios followed by randomized
// operand pairs, checked against a category-table reference model and an
// expected-result queue.
module tb_fp_div_result_stage;

   localparam int SETTLE = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] op_a, op_b, div_m;
   logic        div_overflow, div_underflow;
   logic        in_valid, in_ready;
   logic [31:0] out_data;
   logic        out_valid, out_ready, flag_clr;
   logic        flag_ov, flag_uf, flag_inv, flag_dz;
`ifdef FP_DIV_STATUS_EN
   logic [3:0]  out_status;
   logic [15:0] res_count;
`endif

   logic [35:0] exp_q[$];
   logic [3:0]  flags_m;
   logic [15:0] res_cnt_m;
   int          n_asserts = 0;
   int          n_fail    = 0;
   bit          mon_en    = 1'b0;
   bit          rnd_ready = 1'b0;

   fp_div_result_stage #(.SETTLE_CYCLES(SETTLE)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .op_a          (op_a),
      .op_b          (op_b),
      .div_m         (div_m),
      .div_overflow  (div_overflow),
      .div_underflow (div_underflow),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .flag_clr      (flag_clr),
      .flag_ov       (flag_ov),
      .flag_uf       (flag_uf),
      .flag_inv      (flag_inv),
      .flag_dz       (flag_dz)
`ifdef FP_DIV_STATUS_EN
      ,
      .out_status    (out_status),
      .res_count     (res_count)
`endif
   );

   // Clock
   always #5 clk = ~clk;

   // Watchdog so the run always ends
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: operand categories, then the quotient rules as a table
   typedef enum int {C_ZERO, C_FIN, C_INF, C_NAN} cat_e;

   function automatic cat_e cat_of(input logic [31:0] x);
      int e;
      e = int'(x[30:23]);
      if (e == 0)   return C_ZERO;
      if (e == 255) return (x[22:0] == 0) ? C_INF : C_NAN;
      return C_FIN;
   endfunction

   // Returns {status{ov,uf,inv,dz}, quotient}
   function automatic logic [35:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] m, input logic ov, input logic uf);
      cat_e ca, cb;
      logic s;
      logic [31:0] inf_s, zero_s;
      ca     = cat_of(a);
      cb     = cat_of(b);
      s      = a[31] ^ b[31];
      inf_s  = {s, 8'hFF, 23'd0};
      zero_s = {s, 31'd0};
      if (ca == C_NAN || cb == C_NAN)                               return {4'b0000, 32'h7FC00000};
      if ((ca == C_INF && cb == C_INF) || (ca == C_ZERO && cb == C_ZERO)) return {4'b0010, 32'h7FC00000};
      if (ca == C_INF)                                              return {4'b0000, inf_s};
      if (cb == C_INF)                                              return {4'b0000, zero_s};
      if (cb == C_ZERO)                                             return {4'b0001, inf_s};
      if (ca == C_ZERO)                                             return {4'b0000, zero_s};
      if (ov)                                                       return {4'b1000, inf_s};
      if (uf)                                                       return {4'b0100, zero_s};
      return {4'b0000, m};
   endfunction

   function automatic logic [31:0] gen_op(input int c);
      logic [31:0] x;
      x = $urandom;
      case (c)
         0:       x[30:23] = 8'h00;
         1:       x[30:23] = 8'($urandom_range(1, 254));
         2:       begin x[30:23] = 8'hFF; x[22:0] = 23'd0; end
         default: begin x[30:23] = 8'hFF; x[22:0] = 23'($urandom_range(1, 32'h7FFFFF)); end
      endcase
      return x;
   endfunction

   // Output scoreboard: head must match the oldest expected result
   always @(negedge clk) begin
      if (rst_n && mon_en) begin
         chk("out_valid", {35'd0, out_valid}, {35'd0, exp_q.size() != 0});
         if (out_valid && exp_q.size() != 0) begin
            chk("out_data", {4'd0, out_data}, {4'd0, exp_q[0][31:0]});
`ifdef FP_DIV_STATUS_EN
            chk("out_status", {32'd0, out_status}, {32'd0, exp_q[0][35:32]});
`endif
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] m,
                           input logic ov, input logic uf);
      op_a          = a;
      op_b          = b;
      div_m         = m;
      div_overflow  = ov;
      div_underflow = uf;
      in_valid      = 1'b1;
   endtask

   // Wait for the accept pulse, then record the expected result and flags
   task automatic wait_hs(input bit clr_cap, output int cycles);
      logic        hs;
      logic [35:0] r;
      cycles = 0;
      hs     = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         hs = in_ready;
         if (hs && clr_cap) flag_clr = 1'b1;
         cycles++;
         tick();
         flag_clr = 1'b0;
         if (hs) begin
            r = ref_model(op_a, op_b, div_m, div_overflow, div_underflow);
            exp_q.push_back(r);
            flags_m   = (clr_cap ? 4'd0 : flags_m) | r[35:32];
            res_cnt_m = res_cnt_m + 16'd1;
            chk("flags", {32'd0, flag_ov, flag_uf, flag_inv, flag_dz}, {32'd0, flags_m});
`ifdef FP_DIV_STATUS_EN
            chk("res_count", {20'd0, res_count}, {20'd0, res_cnt_m});
`endif
            break;
         end
      end
      if (!hs) chk("handshake_timeout", 36'd0, 36'd1);
   endtask

   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] m,
                        input logic ov, input logic uf, input bit clr_cap);
      int cyc;
      start_op(a, b, m, ov, uf);
      wait_hs(clr_cap, cyc);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int i = 0; i < 16 && exp_q.size() != 0; i++) tick();
      tick();
      chk("drain_empty", 36'(exp_q.size()), 36'd0);
   endtask

   initial begin
      int cyc;
      logic [31:0] xval;
      rst_n = 1'b0; op_a = '0; op_b = '0; div_m = '0;
      div_overflow = 1'b0; div_underflow = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; flag_clr = 1'b0;
      flags_m = 4'd0; res_cnt_m = 16'd0;

      // Reset state
      #3;
      chk("rst_in_ready", {35'd0, in_ready}, 36'd0);
      chk("rst_out_valid", {35'd0, out_valid}, 36'd0);
      chk("rst_out_data", {4'd0, out_data}, 36'd0);
      chk("rst_flags", {32'd0, flag_ov, flag_uf, flag_inv, flag_dz}, 36'd0);
`ifdef FP_DIV_STATUS_EN
      chk("rst_res_count", {20'd0, res_count}, 36'd0);
`endif
      tick(); tick();
      rst_n  = 1'b1;
      mon_en = 1'b1;
      tick();

      // 1: latency of a plain 6/2 division
      start_op(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);
      @(negedge clk); chk("t1_ready_c0", {35'd0, in_ready}, 36'd0);
      tick();
      @(negedge clk); chk("t1_ready_c1", {35'd0, in_ready}, 36'd0);
      tick();
      wait_hs(1'b0, cyc);
      chk("t1_ready_cycle", 36'(cyc), 36'd1);
      in_valid = 1'b0;
      @(negedge clk); chk("t1_out_data", {4'd0, out_data}, {4'd0, 32'h40400000});
      tick();
      drain();

      // 2: divide by zero and 0/0 with an undefined divider output
      do_op(32'h3F800000, 32'h00000000, $urandom, 1'b0, 1'b0, 1'b0);
      xval = 32'hxxxxxxxx;
      do_op(32'h00000000, 32'h00000000, xval, 1'b0, 1'b0, 1'b0);
      drain();

      // 3: infinities and NaN after a standalone flag clear
      flag_clr = 1'b1; tick(); flag_clr = 1'b0; flags_m = 4'd0;
      chk("t3_clear", {32'd0, flag_ov, flag_uf, flag_inv, flag_dz}, 36'd0);
      do_op(32'hFF800000, 32'h40000000, $urandom, 1'b0, 1'b0, 1'b0);
      do_op(32'h40000000, 32'h7F800000, $urandom, 1'b0, 1'b0, 1'b0);
      do_op(32'h7FC00001, 32'h3F800000, $urandom, 1'b0, 1'b0, 1'b0);
      drain();

      // 4: overflow, then underflow with a clear on its capture cycle
      do_op(32'h7F000000, 32'h00800000, $urandom, 1'b1, 1'b0, 1'b0);
      do_op(32'h00800000, 32'h7F000000, $urandom, 1'b0, 1'b1, 1'b1);
      chk("t4_flags", {32'd0, flag_ov, flag_uf, flag_inv, flag_dz}, {32'd0, 4'b0100});
      drain();

      // 5: back-to-back into a stalled FIFO, third op waits for a pop
      out_ready = 1'b0;
      start_op(32'h3F800000, 32'h40000000, 32'h3F000000, 1'b0, 1'b0);
      wait_hs(1'b0, cyc);
      start_op(32'h40400000, 32'h3F800000, 32'h40400000, 1'b0, 1'b0);
      wait_hs(1'b0, cyc);
      start_op(32'h41000000, 32'h40000000, 32'h40800000, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); chk("t5_full_hold", {35'd0, in_ready}, 36'd0);
         tick();
      end
      out_ready = 1'b1;
      wait_hs(1'b0, cyc);
      in_valid = 1'b0;
      drain();
      start_op(32'h40000000, 32'h40000000, 32'h3F800000, 1'b0, 1'b0);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("t5_abort_no_entry", {35'd0, out_valid}, 36'd0);

      // 6: asynchronous reset in the middle of a wait
      out_ready = 1'b0;
      do_op(32'h3F800000, 32'h00000000, $urandom, 1'b0, 1'b0, 1'b0);
      start_op(32'h40000000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0);
      tick();
      rst_n = 1'b0;
      #1;
      chk("t6_in_ready", {35'd0, in_ready}, 36'd0);
      chk("t6_out_valid", {35'd0, out_valid}, 36'd0);
      chk("t6_out_data", {4'd0, out_data}, 36'd0);
      chk("t6_flags", {32'd0, flag_ov, flag_uf, flag_inv, flag_dz}, 36'd0);
      exp_q.delete();
      flags_m = 4'd0; res_cnt_m = 16'd0;
      in_valid = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      chk("t6_no_stale", {35'd0, out_valid}, 36'd0);
      out_ready = 1'b1;
      do_op(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0);
      drain();
`ifdef FP_DIV_STATUS_EN
      chk("t6_res_count", {20'd0, res_count}, 36'd1);
`endif

      // Random operand pairs with random consumer stalls, clears and aborts
      rnd_ready = 1'b1;
      for (int n = 0; n < 40; n++) begin
         logic [31:0] a, b;
         a = gen_op(int'($urandom_range(0, 3)));
         b = gen_op(int'($urandom_range(0, 3)));
         if ($urandom_range(0, 9) == 0) begin
            start_op(a, b, $urandom, 1'b0, 1'b0);
            tick();
            in_valid = 1'b0;
            tick();
         end else begin
            do_op(a, b, $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0));
         end
      end
      rnd_ready = 1'b0;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
